// File: rtl/sail_print_pkg.sv
// sail_print_pkg: FSM state encoding, character constants and hex-digit helper
// shared by the sail_print_arbiter files.
package sail_print_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFIX_ID,
        ST_PREFIX_SEP,
        ST_BODY,
        ST_NEWLINE
    } print_arb_state_t;

    localparam logic [7:0] SAIL_CHAR_NL    = 8'h0A;
    localparam logic [7:0] SAIL_CHAR_COLON = 8'h3A;

    function automatic logic [7:0] hex_digit(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h57 + {4'h0, v};
    endfunction
endpackage

// File: rtl/sail_print_arbiter_rr_pick.sv
// sail_rr_pick: combinational round-robin picker; returns the first set request
// at or after rr_ptr, wrapping modulo N_REQ.
module sail_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       rr_ptr,
    output logic             any,
    output logic [3:0]       idx
);
    logic [N_REQ-1:0] w_rot;
    logic [4:0]       w_off;
    logic [4:0]       w_sum;

    // Rotate so that bit 0 is the requester at rr_ptr.
    assign w_rot = N_REQ'({req, req} >> rr_ptr);
    assign any   = |req;

    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = 5'(k);
    end

    assign w_sum = {1'b0, rr_ptr} + w_off;
    assign idx   = 4'((w_sum >= 5'(N_REQ)) ? w_sum - 5'(N_REQ) : w_sum);
endmodule

// File: rtl/sail_print_arbiter.sv
// sail_print_arbiter: message-atomic round-robin arbiter sharing one Sail stdout byte sink.
// Define SAIL_PRINT_ARB_PREFIX_EN to prefix each message with "<hex id>:".
module sail_print_arbiter
    import sail_print_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [N_REQ-1:0]   req_endline,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic [3:0]         grant_id,
    output logic [CNT_W-1:0]   msg_count
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    print_arb_state_t r_state;
    logic [3:0]       r_rr_ptr;
    logic [3:0]       r_grant;
    logic [CNT_W-1:0] r_msg_count;
    logic             r_endline_q;

    logic             w_any;
    logic [3:0]       w_idx;
    logic [IW-1:0]    w_g;
    logic [7:0]       w_bytes [N_REQ];
    logic             w_gv;
    logic [7:0]       w_gd;
    logic             w_fire;

    sail_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .idx    (w_idx)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign w_bytes[i] = req_data[8*i +: 8];
    end

    assign w_g       = r_grant[IW-1:0];
    assign w_gv      = req_valid[w_g];
    assign w_gd      = w_bytes[w_g];
    assign w_fire    = (r_state == ST_BODY) && w_gv && out_ready;
    assign busy      = r_state != ST_IDLE;
    assign grant_id  = r_grant;
    assign msg_count = r_msg_count;

    // Only the granted requester sees the sink's ready, and only in BODY.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_BODY) req_ready[w_g] = out_ready;
    end

`ifdef SAIL_PRINT_ARB_PREFIX_EN
    assign out_valid = (r_state == ST_BODY)    ? w_gv :
                       (r_state == ST_NEWLINE) ? r_endline_q :
                       (r_state == ST_PREFIX_ID) || (r_state == ST_PREFIX_SEP);
    assign out_data  = (r_state == ST_BODY)       ? w_gd :
                       (r_state == ST_PREFIX_ID)  ? hex_digit(r_grant) :
                       (r_state == ST_PREFIX_SEP) ? SAIL_CHAR_COLON :
                       (r_state == ST_NEWLINE)    ? SAIL_CHAR_NL : 8'h00;
`else
    assign out_valid = (r_state == ST_BODY) ? w_gv : (r_state == ST_NEWLINE) && r_endline_q;
    assign out_data  = (r_state == ST_BODY) ? w_gd : (r_state == ST_NEWLINE) ? SAIL_CHAR_NL : 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_msg_count <= '0;
            r_endline_q <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_grant <= w_idx;
`ifdef SAIL_PRINT_ARB_PREFIX_EN
                    r_state <= ST_PREFIX_ID;
`else
                    r_state <= ST_BODY;
`endif
                end
`ifdef SAIL_PRINT_ARB_PREFIX_EN
                ST_PREFIX_ID:  if (out_ready) r_state <= ST_PREFIX_SEP;
                ST_PREFIX_SEP: if (out_ready) r_state <= ST_BODY;
`endif
                ST_BODY: if (w_fire && req_last[w_g]) begin
                    r_endline_q <= req_endline[w_g];
                    r_rr_ptr    <= (r_grant == 4'(N_REQ - 1)) ? 4'd0 : r_grant + 4'd1;
                    if (req_endline[w_g]) begin
                        r_state <= ST_NEWLINE;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_msg_count <= r_msg_count + 1'b1;
                    end
                end
                ST_NEWLINE: if (out_ready) begin
                    r_state     <= ST_IDLE;
                    r_msg_count <= r_msg_count + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sail_print_arbiter.sv
// tb_sail_print_arbiter: per-requester beat drivers fed from queues; expected sink bytes
// are queued at issue time and a monitor checks every accepted output byte.
`timescale 1ns/1ps
module tb_sail_print_arbiter;
`ifdef SAIL_PRINT_ARB_PREFIX_EN
    localparam int N   = 12;
    localparam int PFX = 2;
`else
    localparam int N   = 4;
    localparam int PFX = 0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       endl;
        int         gap;
    } beat_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           out_ready = 1'b1;
    logic [N-1:0]   req_valid, req_last, req_endline, req_ready;
    logic [8*N-1:0] req_data;
    logic           out_valid, busy;
    logic [7:0]     out_data;
    logic [3:0]     grant_id;
    logic [31:0]    msg_count;

    beat_t      bq [N][$];
    logic [7:0] exp_q [$];
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    sail_print_arbiter #(.N_REQ(N), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_endline (req_endline),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .msg_count   (msg_count)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    function automatic logic [7:0] hex_ch(input int id);
        return (id < 10) ? 8'(8'h30 + id) : 8'(8'h57 + id);
    endfunction

    // Queue a message's beats for requester id and the bytes the sink should see.
    task automatic msg(input int id, input string s, input bit endl, input int gap_at, input int gap);
        beat_t b;
`ifdef SAIL_PRINT_ARB_PREFIX_EN
        exp_q.push_back(hex_ch(id));
        exp_q.push_back(8'h3A);
`endif
        for (int j = 0; j < s.len(); j++) begin
            b.d    = s[j];
            b.last = (j == s.len() - 1);
            b.endl = endl;
            b.gap  = (j == gap_at) ? gap : 0;
            bq[id].push_back(b);
            exp_q.push_back(s[j]);
        end
        if (endl) exp_q.push_back(8'h0A);
    endtask

    for (genvar i = 0; i < N; i++) begin : g_drv
        logic       v = 1'b0;
        logic [7:0] d = 8'h00;
        logic       l = 1'b0;
        logic       e = 1'b0;
        assign req_valid[i]     = v;
        assign req_data[8*i +: 8] = d;
        assign req_last[i]      = l;
        assign req_endline[i]   = e;
        initial begin
            beat_t b;
            int    t;
            forever begin
                if (bq[i].size() == 0) begin
                    v = 1'b0;
                    @(posedge clk); #1;
                end else begin
                    b = bq[i].pop_front();
                    if (b.gap > 0) begin
                        v = 1'b0;
                        repeat (b.gap) begin @(posedge clk); #1; end
                    end
                    v = 1'b1; d = b.d; l = b.last; e = b.endl;
                    t = 0;
                    @(negedge clk);
                    while (!req_ready[i] && t < 300) begin @(negedge clk); t++; end
                    chk("beat_accept", {31'b0, req_ready[i]}, 1);
                    @(posedge clk); #1;
                end
            end
        end
    end

    // Monitor: every accepted byte must be the next expected byte; held bytes stay stable.
    initial begin
        logic       p_hold = 1'b0;
        logic [7:0] p_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_hold = 1'b0;
            end else begin
                if (p_hold) begin
                    chk("hold_valid", {31'b0, out_valid}, 1);
                    chk("hold_data", {24'b0, out_data}, {24'b0, p_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_byte", {24'b0, out_data}, 32'hFFFF_FFFF);
                    else chk("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
                end
                chk("nongrant_ready", 32'(req_ready & ~(N'(1) << grant_id)), 0);
                p_hold = out_valid && !out_ready;
                p_data = out_data;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end
        while ((busy || exp_q.size() != 0 || |req_valid) && t < 500);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_busy", {31'b0, busy}, 0);
    endtask

    task automatic wait_out(input logic [7:0] dd);
        int t = 0;
        do begin @(negedge clk); t++; end
        while (!(out_valid && out_data == dd) && t < 100);
        chk("wait_out", {24'b0, out_data}, {24'b0, dd});
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        int t;
        int nx;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_grant", {28'b0, grant_id}, 0);
        chk("rst_count", msg_count, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        reset = 1'b0;

        // Requester 1 "hi" + newline: 1 grant cycle then consecutive bytes.
        @(negedge clk); msg(1, "hi", 1, -1, 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!req_valid[1] && t < 50);
        chk("t1_grant_cycle", {31'b0, out_valid}, 0);
        for (int k = 0; k < 3 + PFX; k++) begin
            @(negedge clk);
            chk("t1_stream_valid", {31'b0, out_valid}, 1);
        end
        @(negedge clk);
        chk("t1_busy", {31'b0, busy}, 0);
        chk("t1_count", msg_count, 1);
        chk("t1_grant", {28'b0, grant_id}, 1);

        // rr_ptr is now 2: requesters 0 and 3 together, 3 must win.
        @(negedge clk); msg(3, "3", 0, -1, 0); msg(0, "0", 0, -1, 0);
        wait_idle();
        chk("t1b_count", msg_count, 3);
        chk("t1b_grant", {28'b0, grant_id}, 0);

        // After reset rr_ptr=0: requesters 0 and 2 each send "AB", no interleave.
        pulse_reset();
        chk("t2_rst_count", msg_count, 0);
        @(negedge clk); msg(0, "AB", 0, -1, 0); msg(2, "AB", 0, -1, 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!out_valid && t < 50);
        chk("t2_first_grant", {28'b0, grant_id}, 0);
        wait_idle();
        chk("t2_count", msg_count, 2);
        chk("t2_grant", {28'b0, grant_id}, 2);

        // Requester 0 "xyz" with out_ready toggling.
        @(negedge clk); msg(0, "xyz", 0, -1, 0);
        nx = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1 out_ready = (k % 2 == 0);
            @(negedge clk);
            if (busy && out_valid && out_data inside {8'h78, 8'h79, 8'h7A})
                chk("t3_ready_mirror", {31'b0, req_ready[0]}, {31'b0, out_ready});
            if (out_valid && out_ready) nx++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        chk("t3_transfers", nx, 3 + PFX);
        wait_idle();
        chk("t3_count", msg_count, 3);

        // Requester 3 stalls 5 cycles mid-message while requester 1 waits.
        @(negedge clk); msg(3, "st", 0, 1, 5);
        wait_out(8'h73);
        chk("t4_grant", {28'b0, grant_id}, 3);
        msg(1, "u", 0, -1, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_busy", {31'b0, busy}, 1);
            chk("t4_req1_ready", {31'b0, req_ready[1]}, 0);
            chk("t4_stall_grant", {28'b0, grant_id}, 3);
            chk("t4_stall_valid", {31'b0, out_valid}, 0);
        end
        wait_idle();
        chk("t4_count", msg_count, 5);

        // Reset while the newline is pending: no 0A may ever appear.
        @(negedge clk); msg(2, "q", 1, -1, 0);
        void'(exp_q.pop_back());
        wait_out(8'h71);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("t5_nl_valid", {31'b0, out_valid}, 1);
        chk("t5_nl_data", {24'b0, out_data}, 32'h0A);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_out_valid", {31'b0, out_valid}, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_count", msg_count, 0);
        chk("t5_req_ready", 32'(req_ready), 0);
        reset = 1'b0;
        out_ready = 1'b1;
        // rr_ptr back at 0: requester 1 beats requester 3.
        @(negedge clk); msg(1, "1", 0, -1, 0); msg(3, "3", 0, -1, 0);
        wait_idle();
        chk("t5_after_count", msg_count, 2);
        chk("t5_after_grant", {28'b0, grant_id}, 3);

`ifdef SAIL_PRINT_ARB_PREFIX_EN
        // Requester 11 "k": expect 62, 3A, 6B.
        @(negedge clk); msg(11, "k", 0, -1, 0);
        wait_out(8'h62);
        chk("t6_grant", {28'b0, grant_id}, 11);
        wait_idle();
        chk("t6_count", msg_count, 3);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
